sisc_ctrl_mc: RTL and testbench

SISC_CTRL_MC -- requirements
Module: sisc_ctrl_mc

---
 rtl/sisc_ctrl_mc.sv | 180 ++++++++++++++++++
 tb/tb_sisc_ctrl_mc.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sisc_ctrl_mc.sv
// sisc_ctrl_mc: multi-cycle control FSM for the SISC datapath.
// Sequences fetch, decode, execute, data-memory access and register
// writeback, and provides a HALT state left through resume.
// Optional build macro CTRL_MEM_TIMEOUT_EN: a MEM access that waits
// TO_CYCLES cycles without mem_ack raises a sticky mem_err and halts.
module sisc_ctrl_mc #(
    parameter int OPC_W     = 4,
    parameter int MM_W      = 4,
    parameter int ALU_OP_W  = 2,
    parameter int TO_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst_f,
    input  logic [OPC_W-1:0]    opcode,
    input  logic [MM_W-1:0]     mm,
    input  logic [MM_W-1:0]     stat,
    input  logic                mem_ack,
    input  logic                resume,
    output logic                rf_we,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                wb_sel,
    output logic                rd_sel,
    output logic                br_sel,
    output logic                pc_rst,
    output logic                pc_write,
    output logic                pc_sel,
    output logic                ir_load,
    output logic                mem_req,
    output logic                mem_we,
    output logic                halted,
    output logic                mem_err
);

    typedef enum logic [2:0] {
        S_START0,
        S_START1,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WRITEBACK,
        S_HALT
    } state_t;

    localparam logic [OPC_W-1:0] OP_LOD = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_STR = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_BRA = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_BRR = OPC_W'(5);
    localparam logic [OPC_W-1:0] OP_BNE = OPC_W'(6);
    localparam logic [OPC_W-1:0] OP_ALU = OPC_W'(8);
    localparam logic [OPC_W-1:0] OP_HLT = OPC_W'(15);

    state_t r_state;
    state_t w_next;
    logic   w_all_set;
    logic   w_none_set;
    logic   w_to_hit;

    assign w_all_set  = ((mm & stat) == mm);
    assign w_none_set = ((mm & stat) == '0);

`ifdef CTRL_MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TO_CYCLES + 1);

    logic [CNT_W-1:0] r_to_cnt;
    logic             r_mem_err;

    // The cycle that would bring the count to TO_CYCLES; an ack in that
    // same cycle wins, so the ack term is part of the hit condition.
    assign w_to_hit = (r_state == S_MEM) && !mem_ack &&
                      (r_to_cnt == CNT_W'(TO_CYCLES - 1));

    // Count ack-less MEM cycles; held at zero outside MEM so every entry starts clean.
    always_ff @(posedge clk or posedge rst_f) begin
        if (rst_f)
            r_to_cnt <= '0;
        else if (r_state != S_MEM)
            r_to_cnt <= '0;
        else if (!mem_ack)
            r_to_cnt <= r_to_cnt + 1'b1;
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst_f) begin
        if (rst_f)
            r_mem_err <= 1'b0;
        else if (w_to_hit)
            r_mem_err <= 1'b1;
    end

    assign mem_err = r_mem_err;
`else
    assign w_to_hit = 1'b0;
    assign mem_err  = 1'b0;
`endif

    // State register; reset forces START0 asynchronously.
    always_ff @(posedge clk or posedge rst_f) begin
        if (rst_f)
            r_state <= S_START0;
        else
            r_state <= w_next;
    end

    // Next-state and combinational control outputs from present state and IR fields.
    always_comb begin
        w_next   = r_state;
        rf_we    = 1'b0;
        alu_op   = '0;
        wb_sel   = 1'b0;
        rd_sel   = 1'b0;
        br_sel   = 1'b0;
        pc_rst   = 1'b0;
        pc_write = 1'b0;
        pc_sel   = 1'b0;
        ir_load  = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        halted   = 1'b0;
        case (r_state)
            S_START0: begin
                pc_rst = 1'b1;
                w_next = S_START1;
            end
            S_START1: w_next = S_FETCH;
            S_FETCH: begin
                ir_load  = 1'b1;
                pc_write = 1'b1;
                w_next   = S_DECODE;
            end
            S_DECODE: w_next = (opcode == OP_HLT) ? S_HALT : S_EXECUTE;
            S_EXECUTE: begin
                w_next = S_FETCH;
                case (opcode)
                    OP_ALU: begin
                        alu_op = (mm == MM_W'(8)) ? ALU_OP_W'(1) : '0;
                        w_next = S_WRITEBACK;
                    end
                    OP_BRA, OP_BRR: begin
                        if (w_all_set) begin
                            pc_sel   = 1'b1;
                            pc_write = 1'b1;
                            br_sel   = (opcode == OP_BRA);
                        end
                    end
                    OP_BNE: begin
                        if (w_none_set) begin
                            pc_sel   = 1'b1;
                            pc_write = 1'b1;
                            br_sel   = 1'b1;
                        end
                    end
                    OP_LOD, OP_STR: w_next = S_MEM;
                    default: w_next = S_FETCH;
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (opcode == OP_STR);
                if (mem_ack)
                    w_next = (opcode == OP_LOD) ? S_WRITEBACK : S_FETCH;
                else if (w_to_hit)
                    w_next = S_HALT;
            end
            S_WRITEBACK: begin
                rf_we  = 1'b1;
                wb_sel = (opcode == OP_LOD);
                rd_sel = (opcode == OP_ALU);
                w_next = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
                if (resume)
                    w_next = S_FETCH;
            end
            default: w_next = S_START0;
        endcase
    end

endmodule

// File: tb/tb_sisc_ctrl_mc.sv
// Testbench for sisc_ctrl_mc: table-driven instruction vectors, a random
// instruction stream checked against a per-instruction output-sequence
// model, and hand-written reset / timeout sequences.
module tb_sisc_ctrl_mc;

    typedef struct packed {
        logic       rf_we;
        logic [1:0] alu_op;
        logic       wb_sel;
        logic       rd_sel;
        logic       br_sel;
        logic       pc_rst;
        logic       pc_write;
        logic       pc_sel;
        logic       ir_load;
        logic       mem_req;
        logic       mem_we;
        logic       halted;
        logic       mem_err;
    } out_t;

    typedef struct {
        logic [3:0] op;
        logic [3:0] mm;
        logic [3:0] st;
        int         w;
        int         lat;
        out_t       ex;
    } vec_t;

`ifdef CTRL_MEM_TIMEOUT_EN
    localparam int LONG_W = 16;
`else
    localparam int LONG_W = 20;
`endif

    logic       clk = 1'b0;
    logic       rst_f = 1'b1;
    logic [3:0] opcode = '0;
    logic [3:0] mm = '0;
    logic [3:0] stat = '0;
    logic       mem_ack = 1'b0;
    logic       resume = 1'b0;
    logic       rf_we, wb_sel, rd_sel, br_sel, pc_rst, pc_write, pc_sel;
    logic       ir_load, mem_req, mem_we, halted, mem_err;
    logic [1:0] alu_op;

    out_t act;
    out_t RST_V;
    out_t exp_q[$];
    int   wait_kind;  // 0 none, 1 memory wait, 2 halt wait
    int   wait_lo;
    int   wait_hi;
    int   n_checks = 0;
    int   n_fail = 0;
    vec_t tbl[$];

    sisc_ctrl_mc #(.OPC_W(4), .MM_W(4), .ALU_OP_W(2), .TO_CYCLES(16)) dut (
        .clk(clk), .rst_f(rst_f), .opcode(opcode), .mm(mm), .stat(stat),
        .mem_ack(mem_ack), .resume(resume), .rf_we(rf_we), .alu_op(alu_op),
        .wb_sel(wb_sel), .rd_sel(rd_sel), .br_sel(br_sel), .pc_rst(pc_rst),
        .pc_write(pc_write), .pc_sel(pc_sel), .ir_load(ir_load),
        .mem_req(mem_req), .mem_we(mem_we), .halted(halted), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    always_comb act = {rf_we, alu_op, wb_sel, rd_sel, br_sel, pc_rst, pc_write,
                       pc_sel, ir_load, mem_req, mem_we, halted, mem_err};

    task automatic chk(input string name, input out_t a, input out_t e);
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %b required %b", name, a, e);
        end
    endtask

    task automatic chk_int(input string name, input int a, input int e);
        n_checks++;
        if (a != e) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, a, e);
        end
    endtask

    function automatic out_t ex_v(input bit pcw, input bit brs, input int alu, input bit hlt);
        out_t o;
        o = '0;
        o.pc_write = pcw;
        o.pc_sel   = pcw;
        o.br_sel   = brs;
        o.alu_op   = 2'(alu);
        o.halted   = hlt;
        return o;
    endfunction

    function automatic void add_vec(input logic [3:0] op, input logic [3:0] m,
                                    input logic [3:0] s, input int w, input int lat,
                                    input out_t ex);
        vec_t v;
        v.op = op; v.mm = m; v.st = s; v.w = w; v.lat = lat; v.ex = ex;
        tbl.push_back(v);
    endfunction

    // Expected output sequence of one instruction, FETCH up to (not including)
    // the next FETCH, derived from the instruction rules.
    function automatic void model(input logic [3:0] op, input logic [3:0] m,
                                  input logic [3:0] s, input int w);
        out_t o;
        bit   taken;
        exp_q.delete();
        wait_kind = 0; wait_lo = -1; wait_hi = -1;
        o = '0; o.ir_load = 1'b1; o.pc_write = 1'b1;
        exp_q.push_back(o);
        exp_q.push_back('0);
        if (op == 4'd15) begin
            o = '0; o.halted = 1'b1;
            for (int i = 0; i < w; i++) exp_q.push_back(o);
            wait_kind = 2; wait_lo = 2; wait_hi = 1 + w;
            return;
        end
        o = '0;
        case (op)
            4'd8: o.alu_op = (m == 4'd8) ? 2'd1 : 2'd0;
            4'd4, 4'd5, 4'd6: begin
                taken = (op == 4'd6) ? ((m & s) == 4'd0) : ((m & s) == m);
                if (taken) begin
                    o.pc_write = 1'b1;
                    o.pc_sel   = 1'b1;
                    o.br_sel   = (op != 4'd5);
                end
            end
            default: ;
        endcase
        exp_q.push_back(o);
        if (op == 4'd1 || op == 4'd2) begin
            o = '0; o.mem_req = 1'b1; o.mem_we = (op == 4'd2);
            for (int i = 0; i < w; i++) exp_q.push_back(o);
            wait_kind = 1; wait_lo = 3; wait_hi = 2 + w;
        end
        if (op == 4'd8 || op == 4'd1) begin
            o = '0; o.rf_we = 1'b1;
            o.wb_sel = (op == 4'd1);
            o.rd_sel = (op == 4'd8);
            exp_q.push_back(o);
        end
    endfunction

    // Drive one instruction, check every cycle, then report whether the DUT
    // is back in FETCH exactly when the instruction should have completed.
    task automatic run_instr(input logic [3:0] op, input logic [3:0] m,
                             input logic [3:0] s, input int w, input string tag,
                             output out_t exec_seen, output int lat);
        bit in_wait;
        model(op, m, s, w);
        exec_seen = '0;
        for (int k = 0; k < exp_q.size(); k++) begin
            opcode = op; mm = m; stat = s;
            in_wait = (k >= wait_lo) && (k <= wait_hi);
            if (wait_kind == 1 && in_wait) mem_ack = (k == wait_hi);
            else mem_ack = 1'($urandom_range(0, 1));
            if (wait_kind == 2 && in_wait) resume = (k == wait_hi);
            else resume = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk($sformatf("%s op%0d cyc%0d", tag, op, k), act, exp_q[k]);
            if (k == 2) exec_seen = act;
            @(posedge clk); #1;
        end
        lat = ir_load ? exp_q.size() : -1;
    endtask

    // Assert reset mid-cycle, check it acts at once, then walk START0/START1.
    task automatic reset_seq(input string tag);
        rst_f = 1'b1;
        #1;
        chk({tag, " reset immediate"}, act, RST_V);
        @(posedge clk); #1;
        mem_ack = 1'($urandom_range(0, 1)); resume = 1'($urandom_range(0, 1));
        opcode = 4'($urandom);
        #1;
        chk({tag, " reset held"}, act, RST_V);
        rst_f = 1'b0;
        @(negedge clk);
        chk({tag, " START0"}, act, RST_V);
        @(posedge clk); #1;
        @(negedge clk);
        chk({tag, " START1"}, act, out_t'('0));
        @(posedge clk); #1;
    endtask

    initial begin
        out_t ex;
        int   lat;
        logic [3:0] op, m;
        int   w;
        int   cnt;

        RST_V = '0; RST_V.pc_rst = 1'b1;

        add_vec(4'd0,  4'h0, 4'h0, 1, 3, ex_v(0, 0, 0, 0));
        add_vec(4'd8,  4'h8, 4'h5, 1, 4, ex_v(0, 0, 1, 0));
        add_vec(4'd8,  4'h0, 4'hF, 1, 4, ex_v(0, 0, 0, 0));
        add_vec(4'd8,  4'h3, 4'h0, 1, 4, ex_v(0, 0, 0, 0));
        add_vec(4'd4,  4'h3, 4'h7, 1, 3, ex_v(1, 1, 0, 0));
        add_vec(4'd4,  4'h3, 4'h5, 1, 3, ex_v(0, 0, 0, 0));
        add_vec(4'd4,  4'h0, 4'h0, 1, 3, ex_v(1, 1, 0, 0));
        add_vec(4'd5,  4'h2, 4'h2, 1, 3, ex_v(1, 0, 0, 0));
        add_vec(4'd6,  4'h1, 4'h1, 1, 3, ex_v(0, 0, 0, 0));
        add_vec(4'd6,  4'h1, 4'h6, 1, 3, ex_v(1, 1, 0, 0));
        add_vec(4'd1,  4'h0, 4'h0, 3, 7, ex_v(0, 0, 0, 0));
        add_vec(4'd2,  4'h0, 4'h0, 1, 4, ex_v(0, 0, 0, 0));
        add_vec(4'd1,  4'h0, 4'h0, LONG_W, 4 + LONG_W, ex_v(0, 0, 0, 0));
        add_vec(4'd15, 4'h0, 4'h0, 10, 12, ex_v(0, 0, 0, 1));
        add_vec(4'd3,  4'hF, 4'hF, 1, 3, ex_v(0, 0, 0, 0));

        // Reset held from time zero while inputs toggle.
        repeat (2) @(posedge clk);
        #1;
        opcode = 4'd15; mem_ack = 1'b1; resume = 1'b1;
        @(negedge clk);
        chk("reset from power-up", act, RST_V);
        reset_seq("initial");

        foreach (tbl[i]) begin
            run_instr(tbl[i].op, tbl[i].mm, tbl[i].st, tbl[i].w,
                      $sformatf("vec%0d", i), ex, lat);
            chk($sformatf("vec%0d execute", i), ex, tbl[i].ex);
            chk_int($sformatf("vec%0d latency", i), lat, tbl[i].lat);
        end

        for (int n = 0; n < 150; n++) begin
            op = 4'($urandom);
            m  = 4'($urandom);
            if (op == 4'd8 && $urandom_range(0, 1) == 1) m = ($urandom_range(0, 1) == 1) ? 4'd8 : 4'd0;
            w  = (op == 4'd15) ? int'($urandom_range(1, 4)) : int'($urandom_range(1, 6));
            run_instr(op, m, 4'($urandom), w, $sformatf("rnd%0d", n), ex, lat);
        end

        // Reset pulsed while a load waits in MEM.
        model(4'd1, 4'h0, 4'h0, 5);
        for (int k = 0; k < 5; k++) begin
            opcode = 4'd1; mem_ack = 1'b0; resume = 1'b0;
            @(negedge clk);
            chk($sformatf("midmem cyc%0d", k), act, exp_q[k]);
            if (k < 4) begin
                @(posedge clk); #1;
            end
        end
        reset_seq("midmem");
        run_instr(4'd0, 4'h0, 4'h0, 1, "after reset", ex, lat);
        chk_int("after reset latency", lat, 3);

`ifdef CTRL_MEM_TIMEOUT_EN
        // Store with no ack: error and HALT after TO_CYCLES MEM cycles.
        opcode = 4'd2; mem_ack = 1'b0; resume = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        cnt = 0;
        while (cnt < 40) begin
            @(negedge clk);
            if (!mem_req) break;
            cnt++;
            @(posedge clk); #1;
        end
        chk_int("timeout mem cycles", cnt, 16);
        ex = '0; ex.halted = 1'b1; ex.mem_err = 1'b1;
        chk("timeout halt", act, ex);
        resume = 1'b1;
        @(posedge clk); #1;
        resume = 1'b0;
        @(negedge clk);
        ex = '0; ex.ir_load = 1'b1; ex.pc_write = 1'b1; ex.mem_err = 1'b1;
        chk("timeout sticky err", act, ex);
        reset_seq("err clear");
`else
        cnt = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
